// File: rtl/stopwatch_pkg.sv
// Shared types and limits for the MM:SS.cc stopwatch datapath.
package stopwatch_pkg;

  typedef logic [3:0] bcd_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    LAP   = 2'd3
  } state_e;

  typedef struct packed {
    bcd_t min_t;
    bcd_t min_u;
    bcd_t sec_t;
    bcd_t sec_u;
    bcd_t cs_t;
    bcd_t cs_u;
  } time_t;

  localparam bcd_t CS_MAX    = 4'd9;
  localparam bcd_t UNIT_MAX  = 4'd9;
  localparam bcd_t SEC_T_MAX = 4'd5;
  localparam bcd_t MIN_T_MAX = 4'd5;

  localparam time_t TIME_ZERO = '{4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0};
  localparam time_t TIME_MAX  = '{MIN_T_MAX, UNIT_MAX, SEC_T_MAX, UNIT_MAX, CS_MAX, CS_MAX};

  // BCD increment with full ripple carry; 59:59.99 naturally wraps to zero.
  function automatic time_t time_inc(input time_t t);
    time_t r;
    r = t;
    if (t.cs_u != CS_MAX) begin
      r.cs_u = t.cs_u + 4'd1;
    end else begin
      r.cs_u = 4'd0;
      if (t.cs_t != CS_MAX) begin
        r.cs_t = t.cs_t + 4'd1;
      end else begin
        r.cs_t = 4'd0;
        if (t.sec_u != UNIT_MAX) begin
          r.sec_u = t.sec_u + 4'd1;
        end else begin
          r.sec_u = 4'd0;
          if (t.sec_t != SEC_T_MAX) begin
            r.sec_t = t.sec_t + 4'd1;
          end else begin
            r.sec_t = 4'd0;
            if (t.min_u != UNIT_MAX) begin
              r.min_u = t.min_u + 4'd1;
            end else begin
              r.min_u = 4'd0;
              if (t.min_t != MIN_T_MAX) begin
                r.min_t = t.min_t + 4'd1;
              end else begin
                r.min_t = 4'd0;
              end
            end
          end
        end
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/stopwatch_core_tick_sync.sv
// Synchronises an asynchronous divided clock into i_clk and emits one
// single-cycle pulse per rising edge; reusable for any divided clock.
module tick_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_async,
  output logic o_tick
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_edge;

  // Synchroniser chain followed by the edge-history flop.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync <= '0;
      r_edge <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
      r_edge <= r_sync[SYNC_STAGES-1];
    end
  end

  assign o_tick = r_sync[SYNC_STAGES-1] & ~r_edge;

endmodule

// File: rtl/stopwatch_core.sv
// Stopwatch timekeeping: start/stop, lap freeze and clear over a BCD
// MM:SS.cc counter advanced by synchronised 100 Hz ticks.
module stopwatch_core
  import stopwatch_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter bit SATURATE    = 1'b0
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_tick_in,
  input  logic       i_btn_start,
  input  logic       i_btn_lap,
  input  logic       i_btn_clear,
  output logic [3:0] o_min_t,
  output logic [3:0] o_min_u,
  output logic [3:0] o_sec_t,
  output logic [3:0] o_sec_u,
  output logic [3:0] o_cs_t,
  output logic [3:0] o_cs_u,
  output logic       o_running,
  output logic       o_lap_active,
  output logic       o_overflow
);

  state_e r_state;
  state_e w_state_nxt;
  time_t  r_cnt;
  time_t  w_cnt_nxt;
  time_t  r_snap;
  time_t  w_snap_nxt;
  time_t  w_disp;
  logic   r_ovf;
  logic   w_ovf_nxt;
  logic   w_tick;
  logic   w_count_en;

  tick_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_tick_sync (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_async (i_tick_in),
    .o_tick  (w_tick)
  );

  // State, counter, snapshot and sticky overflow registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= IDLE;
      r_cnt   <= TIME_ZERO;
      r_snap  <= TIME_ZERO;
      r_ovf   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_snap  <= w_snap_nxt;
      r_ovf   <= w_ovf_nxt;
    end
  end

  // Next-state logic; start wins over lap when both arrive together.
  always_comb begin
    w_state_nxt = r_state;
    if (i_btn_clear) begin
      w_state_nxt = IDLE;
    end else begin
      case (r_state)
        IDLE:    w_state_nxt = i_btn_start ? RUN : IDLE;
        RUN:     w_state_nxt = i_btn_start ? PAUSE : (i_btn_lap ? LAP : RUN);
        LAP:     w_state_nxt = i_btn_start ? PAUSE : (i_btn_lap ? RUN : LAP);
        PAUSE:   w_state_nxt = i_btn_start ? RUN : PAUSE;
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  assign w_count_en = w_tick && ((r_state == RUN) || (r_state == LAP));

  // Counter datapath; the lap snapshot captures the post-tick value.
  always_comb begin
    w_cnt_nxt  = r_cnt;
    w_snap_nxt = r_snap;
    w_ovf_nxt  = r_ovf;
    if (i_btn_clear) begin
      w_cnt_nxt  = TIME_ZERO;
      w_snap_nxt = TIME_ZERO;
      w_ovf_nxt  = 1'b0;
    end else begin
      if (w_count_en) begin
        if (r_cnt == TIME_MAX) begin
          w_ovf_nxt = 1'b1;
          w_cnt_nxt = SATURATE ? TIME_MAX : TIME_ZERO;
        end else begin
          w_cnt_nxt = time_inc(r_cnt);
        end
      end else begin
        w_cnt_nxt = r_cnt;
      end
      if ((r_state == RUN) && i_btn_lap && !i_btn_start) begin
        w_snap_nxt = w_cnt_nxt;
      end else begin
        w_snap_nxt = r_snap;
      end
    end
  end

  assign w_disp       = (r_state == LAP) ? r_snap : r_cnt;
  assign o_min_t      = w_disp.min_t;
  assign o_min_u      = w_disp.min_u;
  assign o_sec_t      = w_disp.sec_t;
  assign o_sec_u      = w_disp.sec_u;
  assign o_cs_t       = w_disp.cs_t;
  assign o_cs_u       = w_disp.cs_u;
  assign o_running    = (r_state == RUN) || (r_state == LAP);
  assign o_lap_active = (r_state == LAP);
  assign o_overflow   = r_ovf;

endmodule
